// File: rtl/cmos_frame_capture.sv
// ---------------------------------------------------------------------------
// cmos_frame_capture
//
// Front-end capture stage between OV5640-class CMOS sensor pins and the
// downstream RGB565 byte packer. Sensor pins are registered twice (r1, r2).
// The first SKIP_FRAMES frames after reset are discarded while the sensor
// settles. After that, frame-aligned vsync / byte-valid / data are forwarded
// with a fixed 2-pclk latency. Each line and frame is checked against the
// configured geometry.
//
// Ports:
//   pclk        in   sensor pixel clock, rising edge
//   rst_n       in   synchronous active-low reset
//   cmos_vsync  in   sensor vsync, rising edge = frame boundary
//   cmos_href   in   sensor line-valid
//   cmos_data   in   sensor byte [7:0]
//   err_clr     in   clears err_sticky
//   vs_o        out  gated vsync to packer
//   de_o        out  gated byte-valid to packer
//   pdata_o     out  byte to packer [7:0] (0 when de_o low)
//   frame_done  out  pulse: a forwarded frame completed
//   line_err    out  pulse: line byte count != H_BYTES
//   frame_err   out  pulse: frame line count != V_LINES
//   err_sticky  out  [0] line error seen, [1] frame error seen
//
// Optional (macro CMOS_CAPTURE_STATS_EN):
//   meas_bytes  out  byte count of last completed line [15:0]
//   meas_lines  out  line count of last completed frame [11:0]
//   frame_cnt   out  number of frame_done pulses, wrapping [15:0]
// ---------------------------------------------------------------------------
module cmos_frame_capture #(
    parameter int SKIP_FRAMES = 10,
    parameter int H_BYTES     = 2560,
    parameter int V_LINES     = 720
) (
    input  logic        pclk,
    input  logic        rst_n,
    input  logic        cmos_vsync,
    input  logic        cmos_href,
    input  logic [7:0]  cmos_data,
    input  logic        err_clr,
    output logic        vs_o,
    output logic        de_o,
    output logic [7:0]  pdata_o,
    output logic        frame_done,
    output logic        line_err,
    output logic        frame_err,
`ifdef CMOS_CAPTURE_STATS_EN
    output logic [15:0] meas_bytes,
    output logic [11:0] meas_lines,
    output logic [15:0] frame_cnt,
`endif
    output logic [1:0]  err_sticky
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_SKIP = 2'd1;
    localparam logic [1:0] ST_RUN  = 2'd2;

    localparam logic [15:0] SKIP_W = 16'(SKIP_FRAMES);
    localparam logic [15:0] H_W    = 16'(H_BYTES);
    localparam logic [11:0] V_W    = 12'(V_LINES);

    logic        vsync_r1_q, vsync_r1_d, href_r1_q, href_r1_d;
    logic        vsync_r2_q, vsync_r2_d, href_r2_q, href_r2_d;
    logic [7:0]  data_r1_q, data_r1_d;
    logic [1:0]  state_q, state_d;
    logic [15:0] skip_cnt_q, skip_cnt_d;
    logic [15:0] byte_cnt_q, byte_cnt_d;
    logic [11:0] line_cnt_q, line_cnt_d;
    logic        vs_o_q, vs_o_d, de_o_q, de_o_d;
    logic [7:0]  pdata_o_q, pdata_o_d;
    logic        frame_done_q, frame_done_d;
    logic        line_err_q, line_err_d, frame_err_q, frame_err_d;
    logic [1:0]  err_sticky_q, err_sticky_d;
`ifdef CMOS_CAPTURE_STATS_EN
    logic [15:0] meas_bytes_q, meas_bytes_d;
    logic [11:0] meas_lines_q, meas_lines_d;
    logic [15:0] frame_cnt_q, frame_cnt_d;
`endif

    logic        vs_rise, href_fall, byte_en, in_run, run_en;
    logic [11:0] lines_now;

    always_comb begin
        vsync_r1_d   = cmos_vsync;
        href_r1_d    = cmos_href;
        data_r1_d    = cmos_data;
        vsync_r2_d   = vsync_r1_q;
        href_r2_d    = href_r1_q;
        state_d      = state_q;
        skip_cnt_d   = skip_cnt_q;

        vs_rise   = vsync_r1_q & ~vsync_r2_q;
        href_fall = ~href_r1_q & href_r2_q;
        // href during vsync is not part of a line: neither forwarded nor counted
        byte_en   = href_r1_q & ~vsync_r1_q;

        case (state_q)
            ST_IDLE: begin
                if (vs_rise) begin
                    if (SKIP_FRAMES == 0) begin
                        state_d = ST_RUN;
                    end else begin
                        state_d    = ST_SKIP;
                        skip_cnt_d = 16'd1;
                    end
                end
            end
            ST_SKIP: begin
                if (vs_rise) begin
                    if (skip_cnt_q == SKIP_W) state_d = ST_RUN;
                    else                      skip_cnt_d = skip_cnt_q + 16'd1;
                end
            end
            ST_RUN:  state_d = ST_RUN;
            default: state_d = ST_IDLE;
        endcase

        in_run = (state_q == ST_RUN);
        // Include the entering edge so the first vs_o rise lands on the
        // accepted frame boundary rather than one cycle late.
        run_en = in_run | (state_d == ST_RUN);

        vs_o_d    = run_en & vsync_r1_q;
        de_o_d    = run_en & byte_en;
        pdata_o_d = de_o_d ? data_r1_q : 8'd0;

        if (href_fall)
            byte_cnt_d = 16'd0;
        else if (byte_en && byte_cnt_q != 16'hFFFF)
            byte_cnt_d = byte_cnt_q + 16'd1;
        else
            byte_cnt_d = byte_cnt_q;

        line_err_d = in_run & href_fall & (byte_cnt_q != H_W);

        // A line ending on the same cycle as vs_rise belongs to the closing frame
        lines_now = line_cnt_q;
        if (href_fall && line_cnt_q != 12'hFFF)
            lines_now = line_cnt_q + 12'd1;
        line_cnt_d = vs_rise ? 12'd0 : lines_now;

        frame_done_d = in_run & vs_rise;
        frame_err_d  = frame_done_d & (lines_now != V_W);

        // A new error wins over a simultaneous clear
        err_sticky_d = (err_clr ? 2'b00 : err_sticky_q) | {frame_err_d, line_err_d};

`ifdef CMOS_CAPTURE_STATS_EN
        meas_bytes_d = href_fall ? byte_cnt_q : meas_bytes_q;
        meas_lines_d = frame_done_d ? lines_now : meas_lines_q;
        frame_cnt_d  = frame_cnt_q + {15'd0, frame_done_d};
`endif
    end

    always_ff @(posedge pclk) begin
        if (!rst_n) begin
            vsync_r1_q   <= 1'b0;
            href_r1_q    <= 1'b0;
            data_r1_q    <= 8'd0;
            vsync_r2_q   <= 1'b0;
            href_r2_q    <= 1'b0;
            state_q      <= ST_IDLE;
            skip_cnt_q   <= 16'd0;
            byte_cnt_q   <= 16'd0;
            line_cnt_q   <= 12'd0;
            vs_o_q       <= 1'b0;
            de_o_q       <= 1'b0;
            pdata_o_q    <= 8'd0;
            frame_done_q <= 1'b0;
            line_err_q   <= 1'b0;
            frame_err_q  <= 1'b0;
            err_sticky_q <= 2'b00;
`ifdef CMOS_CAPTURE_STATS_EN
            meas_bytes_q <= 16'd0;
            meas_lines_q <= 12'd0;
            frame_cnt_q  <= 16'd0;
`endif
        end else begin
            vsync_r1_q   <= vsync_r1_d;
            href_r1_q    <= href_r1_d;
            data_r1_q    <= data_r1_d;
            vsync_r2_q   <= vsync_r2_d;
            href_r2_q    <= href_r2_d;
            state_q      <= state_d;
            skip_cnt_q   <= skip_cnt_d;
            byte_cnt_q   <= byte_cnt_d;
            line_cnt_q   <= line_cnt_d;
            vs_o_q       <= vs_o_d;
            de_o_q       <= de_o_d;
            pdata_o_q    <= pdata_o_d;
            frame_done_q <= frame_done_d;
            line_err_q   <= line_err_d;
            frame_err_q  <= frame_err_d;
            err_sticky_q <= err_sticky_d;
`ifdef CMOS_CAPTURE_STATS_EN
            meas_bytes_q <= meas_bytes_d;
            meas_lines_q <= meas_lines_d;
            frame_cnt_q  <= frame_cnt_d;
`endif
        end
    end

    assign vs_o       = vs_o_q;
    assign de_o       = de_o_q;
    assign pdata_o    = pdata_o_q;
    assign frame_done = frame_done_q;
    assign line_err   = line_err_q;
    assign frame_err  = frame_err_q;
    assign err_sticky = err_sticky_q;
`ifdef CMOS_CAPTURE_STATS_EN
    assign meas_bytes = meas_bytes_q;
    assign meas_lines = meas_lines_q;
    assign frame_cnt  = frame_cnt_q;
`endif

endmodule

// File: tb/tb_cmos_frame_capture.sv
// ---------------------------------------------------------------------------
// Bench for cmos_frame_capture. Two instances share the sensor pins: one with
// SKIP_FRAMES=2 and one with SKIP_FRAMES=0 (H_BYTES=8, V_LINES=4 for both).
// Frames are generated as lists of lines; the generator records, per pin
// cycle, which frame number the cycle belongs to, where a line of known
// length ended and how many lines the finished frame had. Expected outputs
// are derived from that record two cycles later.
// ---------------------------------------------------------------------------
module tb_cmos_frame_capture;

    localparam int H = 8;
    localparam int V = 4;
    localparam int N = 4096;

    logic pclk = 1'b0;
    logic rst_n = 1'b0;
    logic cmos_vsync = 1'b0, cmos_href = 1'b0, err_clr = 1'b0;
    logic [7:0] cmos_data = 8'd0;

    logic [1:0] o_vs, o_de, o_fd, o_le, o_fe;
    logic [1:0][7:0] o_pd;
    logic [1:0][1:0] o_st;
`ifdef CMOS_CAPTURE_STATS_EN
    logic [1:0][15:0] o_mb, o_fc;
    logic [1:0][11:0] o_ml;
`endif

    always #5 pclk = ~pclk;

    cmos_frame_capture #(.SKIP_FRAMES(2), .H_BYTES(H), .V_LINES(V)) u_skip2 (
        .pclk(pclk), .rst_n(rst_n), .cmos_vsync(cmos_vsync), .cmos_href(cmos_href),
        .cmos_data(cmos_data), .err_clr(err_clr), .vs_o(o_vs[0]), .de_o(o_de[0]),
        .pdata_o(o_pd[0]), .frame_done(o_fd[0]), .line_err(o_le[0]),
        .frame_err(o_fe[0]),
`ifdef CMOS_CAPTURE_STATS_EN
        .meas_bytes(o_mb[0]), .meas_lines(o_ml[0]), .frame_cnt(o_fc[0]),
`endif
        .err_sticky(o_st[0]));

    cmos_frame_capture #(.SKIP_FRAMES(0), .H_BYTES(H), .V_LINES(V)) u_skip0 (
        .pclk(pclk), .rst_n(rst_n), .cmos_vsync(cmos_vsync), .cmos_href(cmos_href),
        .cmos_data(cmos_data), .err_clr(err_clr), .vs_o(o_vs[1]), .de_o(o_de[1]),
        .pdata_o(o_pd[1]), .frame_done(o_fd[1]), .line_err(o_le[1]),
        .frame_err(o_fe[1]),
`ifdef CMOS_CAPTURE_STATS_EN
        .meas_bytes(o_mb[1]), .meas_lines(o_ml[1]), .frame_cnt(o_fc[1]),
`endif
        .err_sticky(o_st[1]));

    int vectors = 0;
    int miscompares = 0;

    // Per-pin-cycle record written by the generator
    logic       p_vs [N];
    logic       p_hr [N];
    logic [7:0] p_dat[N];
    int         frm_a[N];    // frames started up to and including this cycle
    int         lend_a[N];   // length of the line whose href fell here, else -1
    int         flin_a[N];   // lines of the frame closed by a rise here, else -1

    int cyc = 0;
    int frames = 0;
    int prev_lines = 0;
    int pend_lend = -1;
    bit pend_rise = 1'b0;

    logic [1:0] st_e [2];
`ifdef CMOS_CAPTURE_STATS_EN
    int mb_e = 0;
    int ml_e [2];
    int fc_e [2];
`endif

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        vectors++;
        assert (obs === exp_v) else begin
            miscompares++;
            $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp_v);
        end
    endtask

    task automatic model_reset();
        cyc = 0; frames = 0; prev_lines = 0; pend_lend = -1; pend_rise = 1'b0;
        for (int d = 0; d < 2; d++) begin
            st_e[d] = 2'b00;
`ifdef CMOS_CAPTURE_STATS_EN
            ml_e[d] = 0; fc_e[d] = 0;
`endif
        end
`ifdef CMOS_CAPTURE_STATS_EN
        mb_e = 0;
`endif
    endtask

    // Outputs now on the pins reflect pin cycle k; clr is the err_clr just sampled
    task automatic check_cycle(input int k, input logic clr);
        int skip;
        logic ev, ede, efd, efe, ele;
        logic [7:0] epd;
        for (int d = 0; d < 2; d++) begin
            skip = (d == 0) ? 2 : 0;
            ev   = (frm_a[k] > skip) & p_vs[k];
            ede  = (frm_a[k] > skip) & p_hr[k] & ~p_vs[k];
            epd  = ede ? p_dat[k] : 8'd0;
            efd  = (flin_a[k] >= 0) && (frm_a[k] - 1 > skip);
            efe  = efd && (flin_a[k] != V);
            ele  = (lend_a[k] >= 0) && (lend_a[k] != H) && (frm_a[k] > skip);
            st_e[d] = (clr ? 2'b00 : st_e[d]) | {efe, ele};
            chk($sformatf("vs_o[%0d]@%0d", d, k), 32'(o_vs[d]), 32'(ev));
            chk($sformatf("de_o[%0d]@%0d", d, k), 32'(o_de[d]), 32'(ede));
            chk($sformatf("pdata_o[%0d]@%0d", d, k), 32'(o_pd[d]), 32'(epd));
            chk($sformatf("frame_done[%0d]@%0d", d, k), 32'(o_fd[d]), 32'(efd));
            chk($sformatf("frame_err[%0d]@%0d", d, k), 32'(o_fe[d]), 32'(efe));
            chk($sformatf("line_err[%0d]@%0d", d, k), 32'(o_le[d]), 32'(ele));
            chk($sformatf("err_sticky[%0d]@%0d", d, k), 32'(o_st[d]), 32'(st_e[d]));
`ifdef CMOS_CAPTURE_STATS_EN
            if (d == 0 && lend_a[k] >= 0) mb_e = lend_a[k];
            if (efd) begin
                ml_e[d] = flin_a[k];
                fc_e[d] = (fc_e[d] + 1) % 65536;
            end
            chk($sformatf("meas_bytes[%0d]@%0d", d, k), 32'(o_mb[d]), 32'(mb_e));
            chk($sformatf("meas_lines[%0d]@%0d", d, k), 32'(o_ml[d]), 32'(ml_e[d]));
            chk($sformatf("frame_cnt[%0d]@%0d", d, k), 32'(o_fc[d]), 32'(fc_e[d]));
`endif
        end
    endtask

    task automatic tick(input logic vs, input logic hr, input logic [7:0] dat, input logic clr);
        p_vs[cyc] = vs; p_hr[cyc] = hr; p_dat[cyc] = dat;
        lend_a[cyc] = pend_lend; pend_lend = -1;
        if (pend_rise) begin
            frames++;
            flin_a[cyc] = prev_lines;
            pend_rise = 1'b0;
        end else begin
            flin_a[cyc] = -1;
        end
        frm_a[cyc] = frames;
        cmos_vsync = vs; cmos_href = hr; cmos_data = dat; err_clr = clr;
        @(posedge pclk);
        #1;
        if (cyc >= 1) check_cycle(cyc - 1, clr);
        cyc++;
        if (cyc >= N) begin
            $display("FAIL record_overflow: cycle %0d, limit %0d", cyc, N);
            $fatal(1, "record overflow");
        end
    endtask

    task automatic do_reset(input int n);
        rst_n = 1'b0;
        cmos_vsync = 1'b0; cmos_href = 1'b0; cmos_data = 8'd0; err_clr = 1'b0;
        for (int i = 0; i < n; i++) begin
            @(posedge pclk);
            #1;
            for (int d = 0; d < 2; d++) begin
                chk($sformatf("rst_vs_o[%0d]", d), 32'(o_vs[d]), 32'd0);
                chk($sformatf("rst_de_o[%0d]", d), 32'(o_de[d]), 32'd0);
                chk($sformatf("rst_pdata_o[%0d]", d), 32'(o_pd[d]), 32'd0);
                chk($sformatf("rst_pulses[%0d]", d), 32'({o_fd[d], o_le[d], o_fe[d]}), 32'd0);
                chk($sformatf("rst_err_sticky[%0d]", d), 32'(o_st[d]), 32'd0);
`ifdef CMOS_CAPTURE_STATS_EN
                chk($sformatf("rst_frame_cnt[%0d]", d), 32'(o_fc[d]), 32'd0);
                chk($sformatf("rst_meas_lines[%0d]", d), 32'(o_ml[d]), 32'd0);
`endif
            end
        end
        model_reset();
        rst_n = 1'b1;
    endtask

    task automatic send_line(input int n, input bit clr_after);
        int g;
        for (int i = 0; i < n; i++) tick(1'b0, 1'b1, 8'($urandom), 1'b0);
        pend_lend = n;
        tick(1'b0, 1'b0, 8'd0, 1'b0);
        g = 1 + int'($urandom_range(0, 2));
        for (int j = 0; j < g; j++) tick(1'b0, 1'b0, 8'd0, clr_after && (j == 0));
    endtask

    task automatic send_frame(input int nlines, input int bad_idx, input int bad_len,
                              input bit clr_bad, input bit hr_in_vs);
        pend_rise = 1'b1;
        for (int i = 0; i < 3; i++) tick(1'b1, hr_in_vs, 8'($urandom), 1'b0);
        if (!hr_in_vs) begin
            tick(1'b0, 1'b0, 8'd0, 1'b0);
            tick(1'b0, 1'b0, 8'd0, 1'b0);
        end
        for (int l = 0; l < nlines; l++)
            send_line((l == bad_idx) ? bad_len : H, clr_bad && (l == bad_idx));
        prev_lines = nlines;
    endtask

    initial begin
        do_reset(4);
        for (int i = 0; i < 3; i++) tick(1'b0, 1'b0, 8'd0, 1'b0);

        send_frame(4, -1, 0, 1'b0, 1'b0);   // frame 1
        send_frame(4,  1, 7, 1'b0, 1'b0);   // frame 2: short line, skipped by u_skip2
        send_frame(4, -1, 0, 1'b0, 1'b0);   // frame 3: first forwarded by u_skip2
        send_frame(4, -1, 0, 1'b0, 1'b0);   // frame 4
        send_frame(4,  2, 7, 1'b0, 1'b0);   // short line in RUN
        send_frame(3, -1, 0, 1'b0, 1'b0);   // short frame
        send_frame(4, -1, 0, 1'b0, 1'b0);   // closes short frame
        tick(1'b0, 1'b0, 8'd0, 1'b1);       // lone err_clr
        tick(1'b0, 1'b0, 8'd0, 1'b0);
        send_frame(4,  0, 7, 1'b1, 1'b0);   // err_clr together with line_err
        send_frame(4, -1, 0, 1'b0, 1'b1);   // href held during vsync
        for (int i = 0; i < 3; i++)
            send_frame(3 + int'($urandom_range(0, 2)), int'($urandom_range(0, 3)),
                       6 + int'($urandom_range(0, 4)), 1'b0, 1'b0);
        send_frame(4, -1, 0, 1'b0, 1'b0);

        // Abort mid-line while both instances are forwarding
        pend_rise = 1'b1;
        for (int i = 0; i < 3; i++) tick(1'b1, 1'b0, 8'd0, 1'b0);
        tick(1'b0, 1'b0, 8'd0, 1'b0);
        for (int i = 0; i < 4; i++) tick(1'b0, 1'b1, 8'($urandom), 1'b0);
        do_reset(3);

        for (int i = 0; i < 3; i++) tick(1'b0, 1'b0, 8'd0, 1'b0);
        for (int f = 0; f < 4; f++) send_frame(4, -1, 0, 1'b0, 1'b0);
        send_frame(0, -1, 0, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) tick(1'b0, 1'b0, 8'd0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
